// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Three-master, single-slave bus arbiter. Masters are granted round-robin
//   starting after the previous owner. The owner keeps the bus for as long as
//   it holds its cyc line. A strobe that goes unacknowledged for TIMEOUT
//   cycles is terminated with a one-cycle error to the owner.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   m_cyc_i/stb_i/we_i per-master cycle, strobe, write enable (bit k = master k)
//   m_adr_i, m_dat_i  packed per-master address / write data, master k at [k*W +: W]
//   m_dat_o           slave read data broadcast to every master
//   m_ack_o, m_err_o  per-master acknowledge / timeout error
//   grant_o           one-hot current owner, zero when the bus is unowned
//   s_cyc_o .. s_dat_o slave-side bus controls, address and write data
//   s_dat_i, s_ack_i  slave read data and acknowledge

module mem_bus_arbiter #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DATA_W  = 18,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            m_cyc_i,
    input  logic [2:0]            m_stb_i,
    input  logic [2:0]            m_we_i,
    input  logic [3*ADDR_W-1:0]   m_adr_i,
    input  logic [3*DATA_W-1:0]   m_dat_i,
    output logic [DATA_W-1:0]     m_dat_o,
    output logic [2:0]            m_ack_o,
    output logic [2:0]            m_err_o,
    output logic [2:0]            grant_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_W-1:0]     s_adr_o,
    output logic [DATA_W-1:0]     s_dat_o,
    input  logic [DATA_W-1:0]     s_dat_i,
    input  logic                  s_ack_i
);

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StBusy, StErr} state_e;

    state_e      state_q;
    logic [1:0]  owner_q;
    logic [1:0]  last_owner_q;
    logic [7:0]  cnt_q;

    logic              own_cyc;
    logic              own_stb;
    logic              own_we;
    logic [ADDR_W-1:0] own_adr;
    logic [DATA_W-1:0] own_dat;
    logic [2:0]        owner_oh;
    logic              busy;
    logic              timeout;
    logic [1:0]        pick;

    // Owner's bus signals.
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_adr = '0;
        own_dat = '0;
        unique case (owner_q)
            2'd0: begin
                own_cyc = m_cyc_i[0];
                own_stb = m_stb_i[0];
                own_we  = m_we_i[0];
                own_adr = m_adr_i[0 +: ADDR_W];
                own_dat = m_dat_i[0 +: DATA_W];
            end
            2'd1: begin
                own_cyc = m_cyc_i[1];
                own_stb = m_stb_i[1];
                own_we  = m_we_i[1];
                own_adr = m_adr_i[ADDR_W +: ADDR_W];
                own_dat = m_dat_i[DATA_W +: DATA_W];
            end
            default: begin
                own_cyc = m_cyc_i[2];
                own_stb = m_stb_i[2];
                own_we  = m_we_i[2];
                own_adr = m_adr_i[2*ADDR_W +: ADDR_W];
                own_dat = m_dat_i[2*DATA_W +: DATA_W];
            end
        endcase
    end

    // Round-robin pick: scan from the highest-priority candidate down so the
    // first requester after last_owner is the one left in pick.
    always_comb begin
        pick = 2'd0;
        for (int i = 2; i >= 0; i--) begin
            int idx;
            idx = (int'(last_owner_q) + 1 + i) % 3;
            if (m_cyc_i[idx]) pick = 2'(idx);
        end
    end

    assign owner_oh = 3'b001 << owner_q;
    assign busy     = (state_q == StBusy);
    // An ack in the same cycle pre-empts the timeout.
    assign timeout  = busy & own_cyc & own_stb & ~s_ack_i & (cnt_q >= TimeoutCnt);

    assign grant_o = (state_q != StIdle) ? owner_oh : 3'b000;
    assign s_cyc_o = busy & own_cyc & ~timeout;
    assign s_stb_o = busy & own_stb & ~timeout;
    assign s_we_o  = busy & own_we;
    assign s_adr_o = busy ? own_adr : '0;
    assign s_dat_o = busy ? own_dat : '0;
    assign m_ack_o = (busy & s_ack_i & own_stb) ? owner_oh : 3'b000;
    assign m_err_o = timeout ? owner_oh : 3'b000;
    assign m_dat_o = s_dat_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            owner_q      <= 2'd0;
            last_owner_q <= 2'd2;
            cnt_q        <= 8'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cnt_q <= 8'd0;
                    if (|m_cyc_i) begin
                        owner_q <= pick;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    if (!own_cyc) begin
                        state_q      <= StIdle;
                        last_owner_q <= owner_q;
                        cnt_q        <= 8'd0;
                    end else if (timeout) begin
                        state_q <= StErr;
                        cnt_q   <= 8'd0;
                    end else if (s_ack_i || !own_stb) begin
                        cnt_q <= 8'd0;
                    end else if (cnt_q != 8'hFF) begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StErr: begin
                    cnt_q <= 8'd0;
                    if (!own_cyc) begin
                        state_q      <= StIdle;
                        last_owner_q <= owner_q;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Directed bench for mem_bus_arbiter with default parameters. Inputs are
//   driven 2 ns after each rising edge and outputs checked shortly after.

module tb_mem_bus_arbiter;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 18;

    logic                clk;
    logic                rst_n;
    logic [2:0]          m_cyc_i;
    logic [2:0]          m_stb_i;
    logic [2:0]          m_we_i;
    logic [3*ADDR_W-1:0] m_adr_i;
    logic [3*DATA_W-1:0] m_dat_i;
    logic [DATA_W-1:0]   m_dat_o;
    logic [2:0]          m_ack_o;
    logic [2:0]          m_err_o;
    logic [2:0]          grant_o;
    logic                s_cyc_o;
    logic                s_stb_o;
    logic                s_we_o;
    logic [ADDR_W-1:0]   s_adr_o;
    logic [DATA_W-1:0]   s_dat_o;
    logic [DATA_W-1:0]   s_dat_i;
    logic                s_ack_i;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(15)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .m_cyc_i(m_cyc_i),
        .m_stb_i(m_stb_i),
        .m_we_i (m_we_i),
        .m_adr_i(m_adr_i),
        .m_dat_i(m_dat_i),
        .m_dat_o(m_dat_o),
        .m_ack_o(m_ack_o),
        .m_err_o(m_err_o),
        .grant_o(grant_o),
        .s_cyc_o(s_cyc_o),
        .s_stb_o(s_stb_o),
        .s_we_o (s_we_o),
        .s_adr_o(s_adr_o),
        .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_grant"}, 32'(grant_o), 32'h0);
        chk({tag, "_ack"}, 32'(m_ack_o), 32'h0);
        chk({tag, "_err"}, 32'(m_err_o), 32'h0);
        chk({tag, "_sctl"}, {29'h0, s_cyc_o, s_stb_o, s_we_o}, 32'h0);
        chk({tag, "_sadr"}, 32'(s_adr_o), 32'h0);
        chk({tag, "_sdat"}, 32'(s_dat_o), 32'h0);
    endtask

    initial begin
        rst_n   = 1'b0;
        m_cyc_i = 3'b000;
        m_stb_i = 3'b000;
        m_we_i  = 3'b000;
        m_adr_i = {12'h333, 12'h222, 12'h111};
        m_dat_i = {18'h03333, 18'h02222, 18'h01111};
        s_dat_i = 18'h0;
        s_ack_i = 1'b0;

        // Reset state
        #1;
        m_cyc_i = 3'b111;
        m_stb_i = 3'b111;
        m_we_i  = 3'b111;
        #1;
        chk_idle_outputs("reset");
        tick();
        tick();
        chk_idle_outputs("reset_held");
        m_cyc_i = 3'b000;
        m_stb_i = 3'b000;
        m_we_i  = 3'b000;
        rst_n   = 1'b1;
        tick();
        chk("idle_no_req_grant", 32'(grant_o), 32'h0);

        // Round robin with all masters requesting
        m_cyc_i = 3'b111;
        tick();
        chk("rr0_grant", 32'(grant_o), 32'h1);
        chk("rr0_scyc", 32'(s_cyc_o), 32'h1);
        m_cyc_i = 3'b110;
        #1;
        chk("rr0_release_scyc", 32'(s_cyc_o), 32'h0);
        tick();
        chk("rr0_idle_grant", 32'(grant_o), 32'h0);
        m_cyc_i = 3'b111;
        tick();
        chk("rr1_grant", 32'(grant_o), 32'h2);
        m_cyc_i = 3'b101;
        tick();
        m_cyc_i = 3'b111;
        tick();
        chk("rr2_grant", 32'(grant_o), 32'h4);
        m_cyc_i = 3'b011;
        tick();
        m_cyc_i = 3'b111;
        tick();
        chk("rr3_grant", 32'(grant_o), 32'h1);
        m_cyc_i = 3'b000;
        tick();
        chk("rr_done_grant", 32'(grant_o), 32'h0);

        // Master 1 read, slave acks two cycles after strobe
        m_adr_i = {12'h333, 12'h05A, 12'h111};
        m_cyc_i = 3'b010;
        m_stb_i = 3'b010;
        tick();
        chk("rd_grant", 32'(grant_o), 32'h2);
        chk("rd_sadr", 32'(s_adr_o), 32'h05A);
        chk("rd_sctl", {29'h0, s_cyc_o, s_stb_o, s_we_o}, 32'h6);
        chk("rd_ack_early", 32'(m_ack_o), 32'h0);
        tick();
        tick();
        s_ack_i = 1'b1;
        s_dat_i = 18'h2A5F0;
        #1;
        chk("rd_ack", 32'(m_ack_o), 32'h2);
        chk("rd_mdat", 32'(m_dat_o), 32'h2A5F0);
        chk("rd_err", 32'(m_err_o), 32'h0);
        m_stb_i = 3'b000;
        #1;
        chk("rd_ack_nostb", 32'(m_ack_o), 32'h0);
        s_ack_i = 1'b0;
        tick();
        chk("rd_ack_gone", 32'(m_ack_o), 32'h0);
        chk("rd_hold_grant", 32'(grant_o), 32'h2);
        m_cyc_i = 3'b000;
        tick();
        s_ack_i = 1'b1;
        #1;
        chk("idle_ack_ignored", 32'(m_ack_o), 32'h0);
        s_ack_i = 1'b0;

        // Master 0 write burst while master 2 waits
        m_cyc_i = 3'b001;
        tick();
        chk("burst_grant0", 32'(grant_o), 32'h1);
        m_cyc_i = 3'b101;
        m_we_i  = 3'b001;
        for (int i = 0; i < 3; i++) begin
            m_stb_i = 3'b001;
            m_adr_i = {12'h333, 12'h05A, 12'(12'h100 + i)};
            m_dat_i = {18'h03333, 18'h02222, 18'(18'h10000 + i)};
            s_ack_i = 1'b1;
            #1;
            chk("burst_grant", 32'(grant_o), 32'h1);
            chk("burst_ack", 32'(m_ack_o), 32'h1);
            chk("burst_sadr", 32'(s_adr_o), 32'(12'h100 + i));
            chk("burst_sdat", 32'(s_dat_o), 32'(18'h10000 + i));
            chk("burst_swe", 32'(s_we_o), 32'h1);
            tick();
        end
        m_stb_i = 3'b000;
        m_we_i  = 3'b000;
        s_ack_i = 1'b0;
        #1;
        chk("burst_after_grant", 32'(grant_o), 32'h1);
        m_cyc_i = 3'b100;
        tick();
        chk("burst_rel_idle", 32'(grant_o), 32'h0);
        tick();
        chk("burst_next_grant", 32'(grant_o), 32'h4);

        // Master 2 strobe with no ack: timeout after 15 cycles
        m_stb_i = 3'b100;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k < 15) chk("to_no_err", 32'(m_err_o), 32'h0);
        end
        chk("to_err", 32'(m_err_o), 32'h4);
        chk("to_scyc", {30'h0, s_cyc_o, s_stb_o}, 32'h0);
        tick();
        chk("to_err_once", 32'(m_err_o), 32'h0);
        chk("err_grant", 32'(grant_o), 32'h4);
        chk("err_scyc", 32'(s_cyc_o), 32'h0);
        tick();
        chk("err_hold_grant", 32'(grant_o), 32'h4);
        m_cyc_i = 3'b000;
        m_stb_i = 3'b000;
        tick();
        chk("err_exit_grant", 32'(grant_o), 32'h0);

        // Ack coinciding with the timeout cycle wins
        m_cyc_i = 3'b100;
        tick();
        chk("co_grant", 32'(grant_o), 32'h4);
        m_stb_i = 3'b100;
        for (int k = 1; k <= 15; k++) tick();
        s_ack_i = 1'b1;
        #1;
        chk("co_ack", 32'(m_ack_o), 32'h4);
        chk("co_err", 32'(m_err_o), 32'h0);
        s_ack_i = 1'b0;
        m_stb_i = 3'b000;
        tick();
        chk("co_still_busy", {29'h0, grant_o}, 32'h4);
        chk("co_scyc", 32'(s_cyc_o), 32'h1);
        m_cyc_i = 3'b000;
        tick();

        // Asynchronous reset during master 1 transfer
        m_cyc_i = 3'b010;
        m_stb_i = 3'b010;
        tick();
        chk("ar_grant", 32'(grant_o), 32'h2);
        s_ack_i = 1'b1;
        #1;
        chk("ar_ack_pre", 32'(m_ack_o), 32'h2);
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("ar_reset");
        rst_n   = 1'b1;
        s_ack_i = 1'b0;
        m_cyc_i = 3'b011;
        m_stb_i = 3'b000;
        tick();
        chk("ar_post_grant", 32'(grant_o), 32'h1);

        // Master 1 drops its request before being granted
        m_cyc_i = 3'b001;
        tick();
        m_cyc_i = 3'b100;
        tick();
        tick();
        chk("drop_grant", 32'(grant_o), 32'h4);
        m_cyc_i = 3'b000;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, address width of each master and of the slave.
REQ-002 SHALL have parameter DATA_W, default 18, data width of each master and of the slave.
REQ-003 SHALL have parameter TIMEOUT, default 15, maximum cycles without ack before error (range 1..255).
REQ-004 SHALL have ports, in this order: clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  reset; asynchronous, active-low.
REQ-006 m_cyc_i  in  3  per-master bus-cycle request (bit 0 instruction fetch, bit 1 data, bit 2 DMA/debug).
REQ-007 m_stb_i  in  3  per-master transfer strobe.
REQ-008 m_we_i  in  3  per-master write enable.
REQ-009 m_adr_i  in  3*ADDR_W  packed addresses, master k at bits [k*ADDR_W +: ADDR_W].
REQ-010 m_dat_i  in  3*DATA_W  packed write data, same packing.
REQ-011 m_dat_o  out  DATA_W  read data broadcast to all masters (= s_dat_i).
REQ-012 m_ack_o  out  3  per-master transfer acknowledge.
REQ-013 m_err_o  out  3  per-master timeout error.
REQ-014 grant_o  out  3  one-hot current owner, all-zero when no owner.
REQ-015 s_cyc_o, s_stb_o, s_we_o  out  1 each  slave bus controls.
REQ-016 s_adr_o  out  ADDR_W; s_dat_o  out  DATA_W  slave address and write data.
REQ-017 s_dat_i  in  DATA_W; s_ack_i  in  1  slave read data and acknowledge.

Function
REQ-018 SHALL implement states IDLE, BUSY, ERR; all state, owner, last_owner and timeout counter registered on clk.
REQ-019 IDLE: if any m_cyc_i bit set, SHALL select owner by round-robin starting at (last_owner+1) mod 3, load owner, enter BUSY next edge; else remain IDLE.
REQ-020 Grant latency: request first seen in IDLE at edge N -> grant_o and s_cyc_o high from cycle after edge N (one cycle).
REQ-021 BUSY: s_cyc_o = m_cyc_i[owner]; s_stb_o, s_we_o, s_adr_o, s_dat_o SHALL combinationally follow owner's inputs.
REQ-022 BUSY: m_ack_o[owner] = s_ack_i & m_stb_i[owner]; other m_ack_o bits 0; s_ack_i outside BUSY or with owner strobe low SHALL be ignored.
REQ-023 BUSY: owner holds bus across multiple strobes (burst/read-modify-write) while m_cyc_i[owner] high; no preemption.
REQ-024 BUSY: m_cyc_i[owner] low -> next edge IDLE, last_owner := owner; new grant earliest two cycles after release cycle.
REQ-025 Timeout counter: clears on s_ack_i, on m_stb_i[owner] low, and on entering BUSY; increments each BUSY cycle with strobe high and no ack; saturating 8 bits.
REQ-026 Counter reaching TIMEOUT SHALL assert m_err_o[owner] for exactly one cycle, deassert s_cyc_o/s_stb_o, enter ERR.
REQ-027 ERR: slave outputs low, grant_o keeps owner, wait for m_cyc_i[owner] low, then IDLE with last_owner := owner.
REQ-028 Simultaneous s_ack_i and timeout in same cycle: ack wins, no error.
REQ-029 Outside BUSY all s_* outputs and m_ack_o SHALL be 0; m_dat_o always = s_dat_i.
REQ-030 Master dropping m_cyc_i before its grant SHALL not be granted if it is low at the IDLE selection edge.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, grant_o=0, m_ack_o=0, m_err_o=0, s_cyc_o=s_stb_o=s_we_o=0, s_adr_o=0, s_dat_o=0, counter=0, last_owner=2 (master 0 first).
REQ-032 Reset mid-transfer SHALL abort silently: no ack or error emitted; first post-reset request arbitrated from master 0.

Verification
REQ-033 After reset, m_cyc_i=3'b111 held -> grants 001, 010, 100, 001 in order, each after owner drops cyc.
REQ-034 Master 1 read adr=0x05A, slave acks 2 cycles after stb with s_dat_i=0x2A5F0 -> m_ack_o=010 for one cycle, m_dat_o=0x2A5F0, no error.
REQ-035 Master 0 burst of 3 strobes under one cyc while master 2 requests -> grant stays 001 for all 3 acks, 100 granted 2 cycles after release.
REQ-036 Master 2 strobe, slave never acks, TIMEOUT=15 -> m_err_o=100 one cycle 15 cycles after strobe, s_cyc_o low, ERR until cyc drops.
REQ-037 Ack and timeout coincide on cycle 15 -> m_ack_o asserted, m_err_o stays 0.
REQ-038 rst_n pulsed low during master 1 BUSY -> all outputs 0 asynchronously; next request with m_cyc_i=011 grants master 0.
